// File: rtl/defl_pkg.sv
// Shared constants and helpers for the deflection router pipeline.
package defl_pkg;

  // Input / service slot indices; the network slots also index output ports.
  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_S = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  localparam int NUM_NET = 4;
  localparam int NUM_IN  = 5;

  // Productive-direction code meaning "this node, no network port".
  localparam logic [2:0] DIR_NONE = 3'd4;

  // Flit field LSB positions; layout MSB..LSB is valid, age, dx, dy, payload.
  function automatic int age_lsb(input int flit_w, input int age_w);
    return flit_w - 1 - age_w;
  endfunction

  function automatic int dx_lsb(input int flit_w, input int age_w, input int x_w);
    return flit_w - 1 - age_w - x_w;
  endfunction

  function automatic int dy_lsb(input int flit_w, input int age_w, input int x_w,
                                input int y_w);
    return flit_w - 1 - age_w - x_w - y_w;
  endfunction

  // Number of enabled output ports in a {W,S,E,N} mask.
  function automatic int popcount4(input logic [3:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) n = n + 1;
    end
    return n;
  endfunction

  // True when age a is strictly older than age b.
  function automatic logic age_older(input int unsigned a, input int unsigned b);
    return a > b;
  endfunction

  // X is resolved before Y; coordinates never wrap.
  function automatic logic [2:0] prod_dir(input int unsigned dx, input int unsigned dy,
                                          input int unsigned my_x, input int unsigned my_y);
    logic [2:0] d;
    if (dx > my_x)      d = 3'(P_E);
    else if (dx < my_x) d = 3'(P_W);
    else if (dy > my_y) d = 3'(P_N);
    else if (dy < my_y) d = 3'(P_S);
    else                d = DIR_NONE;
    return d;
  endfunction

  // Age + 1, clamped to the largest value an age_w-bit field holds.
  function automatic int unsigned age_sat_inc(input int unsigned age, input int unsigned age_w);
    int unsigned max_age;
    max_age = (32'd1 << age_w) - 32'd1;
    return (age >= max_age) ? max_age : age + 32'd1;
  endfunction

endpackage

// File: rtl/defl_age_sort.sv
// Combinational stable sort of five slots by descending age.
// order_o[k] is the slot serviced k-th; equal ages keep slot order N,E,S,W,L.
module defl_age_sort
  import defl_pkg::*;
#(
  parameter int AGE_W = 3
) (
  input  logic [AGE_W-1:0] age_i   [NUM_IN],
  output logic [2:0]       order_o [NUM_IN]
);

  logic [2:0] pos [NUM_IN];

  // Rank each slot by counting the slots that must precede it, then scatter.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      pos[i] = '0;
      for (int j = 0; j < NUM_IN; j++) begin
        if (j != i) begin
          if (age_older(32'(age_i[j]), 32'(age_i[i])) ||
              ((age_i[j] == age_i[i]) && (j < i))) begin
            pos[i] = pos[i] + 3'd1;
          end
        end
      end
    end
    for (int i = 0; i < NUM_IN; i++) order_o[i] = '0;
    for (int i = 0; i < NUM_IN; i++) order_o[pos[i]] = 3'(i);
  end

endmodule

// File: rtl/defl_router_pipe.sv
// Registered 5-port bufferless deflection router: eject one local flit,
// allocate every other flit (plus an optional injection) to a distinct
// enabled output oldest-first, and count deflections.
//
// Local injection handshake: lin carries its own valid bit; lin_ready is
// combinational and, when high in a cycle with lin valid, the flit is taken
// at that clock edge. While lin_ready is low the source holds lin unchanged.
module defl_router_pipe
  import defl_pkg::*;
#(
  parameter int         FLIT_W  = 10,
  parameter int         AGE_W   = 3,
  parameter int         X_W     = 2,
  parameter int         Y_W     = 2,
  parameter int         MY_X    = 1,
  parameter int         MY_Y    = 1,
  parameter logic [3:0] PORT_EN = 4'b1111,
  parameter int         CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] nin,
  input  logic [FLIT_W-1:0] sin,
  input  logic [FLIT_W-1:0] ein,
  input  logic [FLIT_W-1:0] win,
  input  logic [FLIT_W-1:0] lin,
  output logic              lin_ready,
  output logic [FLIT_W-1:0] nout,
  output logic [FLIT_W-1:0] sout,
  output logic [FLIT_W-1:0] eout,
  output logic [FLIT_W-1:0] wout,
  output logic [FLIT_W-1:0] lout,
  output logic [CNT_W-1:0]  defl_cnt
);

  localparam int         AGE_LSB = age_lsb(FLIT_W, AGE_W);
  localparam int         DX_LSB  = dx_lsb(FLIT_W, AGE_W, X_W);
  localparam int         DY_LSB  = dy_lsb(FLIT_W, AGE_W, X_W, Y_W);
  localparam logic [2:0] EN_CNT  = 3'(popcount4(PORT_EN));

  typedef logic [FLIT_W-1:0] flit_t;

  flit_t            in_f   [NUM_IN];
  logic             in_v   [NUM_IN];
  logic [AGE_W-1:0] in_age [NUM_IN];
  logic [X_W-1:0]   in_dx  [NUM_IN];
  logic [Y_W-1:0]   in_dy  [NUM_IN];

  logic             ej_hit;
  logic [1:0]       ej_idx;
  logic [AGE_W-1:0] ej_age;
  logic [2:0]       rem_cnt;
  logic             cand_v [NUM_IN];

  logic [2:0]       order [NUM_IN];
  logic [3:0]       busy;
  logic [2:0]       sel;
  logic [2:0]       dir;
  logic [1:0]       got_port;
  logic             granted;
  logic             is_defl;
  flit_t            tmp_f;
  logic [2:0]       defl_n;

  flit_t            out_d [NUM_NET];
  flit_t            out_q [NUM_NET];
  flit_t            lout_d, lout_q;
  logic [CNT_W+2:0] cnt_sum;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Mask disabled network inputs and split every slot into its fields.
  always_comb begin
    in_f[P_N] = PORT_EN[P_N] ? nin : '0;
    in_f[P_E] = PORT_EN[P_E] ? ein : '0;
    in_f[P_S] = PORT_EN[P_S] ? sin : '0;
    in_f[P_W] = PORT_EN[P_W] ? win : '0;
    in_f[P_L] = lin;
    for (int i = 0; i < NUM_IN; i++) begin
      in_v[i]   = in_f[i][FLIT_W-1];
      in_age[i] = in_f[i][AGE_LSB +: AGE_W];
      in_dx[i]  = in_f[i][DX_LSB +: X_W];
      in_dy[i]  = in_f[i][DY_LSB +: Y_W];
    end
  end

  // Pick the oldest local-destined network flit for ejection, then gate injection.
  always_comb begin
    ej_hit  = 1'b0;
    ej_idx  = '0;
    ej_age  = '0;
    rem_cnt = '0;
    for (int i = 0; i < NUM_NET; i++) begin
      if (in_v[i] && (in_dx[i] == X_W'(MY_X)) && (in_dy[i] == Y_W'(MY_Y)) &&
          (!ej_hit || age_older(32'(in_age[i]), 32'(ej_age)))) begin
        ej_hit = 1'b1;
        ej_idx = 2'(i);
        ej_age = in_age[i];
      end
    end
    for (int i = 0; i < NUM_NET; i++) begin
      cand_v[i] = in_v[i] && !(ej_hit && (ej_idx == 2'(i)));
      if (cand_v[i]) rem_cnt = rem_cnt + 3'd1;
    end
    lin_ready     = rst_n && in_v[P_L] && (rem_cnt < EN_CNT);
    cand_v[P_L]   = lin_ready;
    lout_d        = ej_hit ? in_f[ej_idx] : '0;
  end

  defl_age_sort #(
    .AGE_W (AGE_W)
  ) u_sort (
    .age_i   (in_age),
    .order_o (order)
  );

  // Walk the service order; productive port if free, else first free port.
  always_comb begin
    busy     = ~PORT_EN;
    defl_n   = '0;
    sel      = '0;
    dir      = DIR_NONE;
    got_port = '0;
    granted  = 1'b0;
    is_defl  = 1'b0;
    tmp_f    = '0;
    for (int p = 0; p < NUM_NET; p++) out_d[p] = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      sel = order[k];
      if (cand_v[sel]) begin
        dir      = prod_dir(32'(in_dx[sel]), 32'(in_dy[sel]), 32'(MY_X), 32'(MY_Y));
        granted  = 1'b0;
        got_port = '0;
        is_defl  = 1'b0;
        if ((dir != DIR_NONE) && !busy[dir[1:0]]) begin
          got_port = dir[1:0];
          granted  = 1'b1;
        end else begin
          is_defl = 1'b1;
          for (int p = 0; p < NUM_NET; p++) begin
            if (!granted && !busy[p]) begin
              got_port = 2'(p);
              granted  = 1'b1;
            end
          end
        end
        tmp_f = in_f[sel];
        if (is_defl) begin
          tmp_f[AGE_LSB +: AGE_W] = AGE_W'(age_sat_inc(32'(in_age[sel]), 32'(AGE_W)));
        end
        if (granted) begin
          busy[got_port]  = 1'b1;
          out_d[got_port] = tmp_f;
          defl_n          = defl_n + {2'b00, is_defl};
        end
      end
    end
  end

  // Saturating accumulation of this cycle's deflections.
  always_comb begin
    cnt_sum = {3'b000, cnt_q} + (CNT_W+3)'(defl_n);
    if (|cnt_sum[CNT_W+2:CNT_W]) cnt_d = '1;
    else                         cnt_d = cnt_sum[CNT_W-1:0];
  end

  // Output and counter registers; reset drops any in-flight flits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_NET; p++) out_q[p] <= '0;
      lout_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_NET; p++) out_q[p] <= out_d[p];
      lout_q <= lout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign nout     = out_q[P_N];
  assign eout     = out_q[P_E];
  assign sout     = out_q[P_S];
  assign wout     = out_q[P_W];
  assign lout     = lout_q;
  assign defl_cnt = cnt_q;

endmodule

// File: tb/tb_defl_router_pipe.sv
// Directed bench for defl_router_pipe (MY_X=1, MY_Y=1): a driver pushes the
// hand-computed response of each vector, a monitor pops and compares.
module tb_defl_router_pipe;

  localparam int W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] nin = '0, sin = '0, ein = '0, win = '0, lin = '0;
  logic [W-1:0] nout, sout, eout, wout, lout;
  logic         lin_ready;
  logic [15:0]  defl_cnt;
  logic [W-1:0] nout2, sout2, eout2, wout2, lout2;
  logic         lin_ready2;
  logic [1:0]   defl_cnt2;

  defl_router_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .nin(nin), .sin(sin), .ein(ein), .win(win), .lin(lin),
    .lin_ready(lin_ready),
    .nout(nout), .sout(sout), .eout(eout), .wout(wout), .lout(lout),
    .defl_cnt(defl_cnt)
  );

  defl_router_pipe #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n),
    .nin(nin), .sin(sin), .ein(ein), .win(win), .lin(lin),
    .lin_ready(lin_ready2),
    .nout(nout2), .sout(sout2), .eout(eout2), .wout(wout2), .lout(lout2),
    .defl_cnt(defl_cnt2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic         rst;
    logic [W-1:0] n, e, s, w, l;
    int           inc;
    int           cap;
  } exp_t;

  typedef struct {
    logic rdy;
    int   cap;
  } rdy_t;

  exp_t exp_q[$];
  rdy_t rdy_q[$];

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int exp_cnt2 = 0;

  task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r,
                       input logic [W-1:0] vn, ve, vs, vw, vl,
                       input logic [W-1:0] en, ee, es, ew, el,
                       input int inc, input logic rdy);
    exp_t e;
    rdy_t q;
    @(posedge clk);
    #1;
    rst_n = r;
    nin = vn; ein = ve; sin = vs; win = vw; lin = vl;
    e.rst = !r;
    e.n = en; e.e = ee; e.s = es; e.w = ew; e.l = el;
    e.inc = inc;
    e.cap = cyc + 1;
    exp_q.push_back(e);
    q.rdy = rdy;
    q.cap = cyc + 1;
    rdy_q.push_back(q);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    rdy_t r;
    forever begin
      @(negedge clk);
      if (rdy_q.size() > 0 && rdy_q[0].cap == cyc + 1) begin
        r = rdy_q.pop_front();
        check_val("lin_ready", W'(lin_ready), W'(r.rdy));
        check_val("lin_ready_c2", W'(lin_ready2), W'(r.rdy));
      end
      if (exp_q.size() > 0 && exp_q[0].cap == cyc) begin
        e = exp_q.pop_front();
        if (e.rst) begin
          exp_cnt  = 0;
          exp_cnt2 = 0;
        end else begin
          exp_cnt  = (exp_cnt + e.inc > 65535) ? 65535 : exp_cnt + e.inc;
          exp_cnt2 = (exp_cnt2 + e.inc > 3) ? 3 : exp_cnt2 + e.inc;
        end
        check_val("nout", nout, e.n);
        check_val("eout", eout, e.e);
        check_val("sout", sout, e.s);
        check_val("wout", wout, e.w);
        check_val("lout", lout, e.l);
        check_val("defl_cnt", W'(defl_cnt), W'(exp_cnt));
        check_val("defl_cnt_c2", W'(defl_cnt2), W'(exp_cnt2));
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [W-1:0] Z = '0;
  initial begin
    // reset held two cycles with every input valid
    drive(1'b0, 10'b1_011_10_01_01, 10'b1_010_00_01_10, 10'b1_001_01_00_11,
          10'b1_100_01_10_00, 10'b1_000_00_00_01, Z, Z, Z, Z, Z, 0, 1'b0);
    drive(1'b0, 10'b1_011_10_01_01, 10'b1_010_00_01_10, 10'b1_001_01_00_11,
          10'b1_100_01_10_00, 10'b1_000_00_00_01, Z, Z, Z, Z, Z, 0, 1'b0);
    // straight route east, first cycle out of reset
    drive(1'b1, 10'b1_000_10_01_11, Z, Z, Z, Z,
          Z, 10'b1_000_10_01_11, Z, Z, Z, 0, 1'b0);
    // ejection contention: oldest local flit ejected, the other deflected to N
    drive(1'b1, Z, Z, 10'b1_101_01_01_00, 10'b1_010_01_01_10, Z,
          10'b1_011_01_01_10, Z, Z, Z, 10'b1_101_01_01_00, 1, 1'b0);
    // equal-age tie for E: N wins, S deflected to N with age 2
    drive(1'b1, 10'b1_001_10_01_00, Z, 10'b1_001_10_01_01, Z, Z,
          10'b1_010_10_01_01, 10'b1_001_10_01_00, Z, Z, Z, 1, 1'b0);
    // four network flits fill every port: injection refused
    drive(1'b1, 10'b1_000_10_01_00, 10'b1_000_01_10_00, 10'b1_000_01_00_00,
          10'b1_000_00_01_00, 10'b1_000_00_00_01,
          10'b1_000_01_10_00, 10'b1_000_10_01_00, 10'b1_000_01_00_00,
          10'b1_000_00_01_00, Z, 0, 1'b0);
    // W input empty: held injection accepted, goes west
    drive(1'b1, 10'b1_000_10_01_00, 10'b1_000_01_10_00, 10'b1_000_01_00_00,
          Z, 10'b1_000_00_00_01,
          10'b1_000_01_10_00, 10'b1_000_10_01_00, 10'b1_000_01_00_00,
          10'b1_000_00_00_01, Z, 0, 1'b1);
    // age-7 flit deflected keeps age 7
    drive(1'b1, 10'b1_111_10_01_00, 10'b1_111_10_01_01, Z, Z, Z,
          10'b1_111_10_01_01, 10'b1_111_10_01_00, Z, Z, Z, 1, 1'b0);
    // four local flits: oldest ejected, three deflected to N, E, S
    drive(1'b1, 10'b1_100_01_01_00, 10'b1_011_01_01_01, 10'b1_010_01_01_10,
          10'b1_001_01_01_11, Z,
          10'b1_100_01_01_01, 10'b1_011_01_01_10, 10'b1_010_01_01_11, Z,
          10'b1_100_01_01_00, 3, 1'b0);
    // injection ties with a network flit for E and ranks last
    drive(1'b1, 10'b1_000_10_01_00, Z, Z, Z, 10'b1_000_10_00_11,
          10'b1_001_10_00_11, 10'b1_000_10_01_00, Z, Z, Z, 1, 1'b1);
    // repeated deflections to saturate the 2-bit counter
    drive(1'b1, 10'b1_001_10_01_00, Z, 10'b1_001_10_01_01, Z, Z,
          10'b1_010_10_01_01, 10'b1_001_10_01_00, Z, Z, Z, 1, 1'b0);
    drive(1'b1, 10'b1_001_10_01_00, Z, 10'b1_001_10_01_01, Z, Z,
          10'b1_010_10_01_01, 10'b1_001_10_01_00, Z, Z, Z, 1, 1'b0);
    // idle
    drive(1'b1, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, 0, 1'b0);

    // drain with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && rdy_q.size() == 0) break;
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0 || rdy_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending_outputs=%0d pending_ready=%0d expected=0",
               exp_q.size(), rdy_q.size());
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
